// File: rtl/crc_arb_pkg.sv
// ---------------------------------------------------------------------------
// crc_arb_pkg
// Shared types and constants for the CRC-3 engine scheduler (crc_arbiter).
//   state_e  : scheduler FSM states (IDLE/ISSUE/WAIT/CAPTURE/FLUSH)
//   pick_t   : round-robin pick result (found flag + winning index)
//   rr_pick  : first valid index scanning ptr, ptr+1, ... wrapping at nreq
// ---------------------------------------------------------------------------
package crc_arb_pkg;

    localparam int CRC_W       = 3;
    localparam int NOMINAL_LAT = 130;
    localparam int MAX_REQ     = 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        WAIT    = 3'd2,
        CAPTURE = 3'd3,
        FLUSH   = 3'd4
    } state_e;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } pick_t;

    // Scan candidates in rotating order; the first hit wins and later hits
    // are masked by the found flag, so the result is a single index.
    function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                      input logic [2:0]         ptr,
                                      input int                 nreq);
        pick_t res;
        int    cand;
        logic  hit;
        res.found = 1'b0;
        res.idx   = 3'd0;
        for (int k = 0; k < MAX_REQ; k++) begin
            cand      = (int'(ptr) + k) % nreq;
            hit       = !res.found && (k < nreq) && valid[cand];
            res.idx   = hit ? 3'(cand) : res.idx;
            res.found = res.found | hit;
        end
        return res;
    endfunction

endpackage

// File: rtl/crc_arbiter_if.sv
// ---------------------------------------------------------------------------
// crc_arbiter_if
// Bundles the requester side and the CRC engine side of crc_arbiter.
//   req_valid/req_data/req_ready : NREQ requesters, payload i at [i*DW +: DW]
//   rsp_valid/rsp_id/rsp_crc/rsp_err : one-cycle result strobe to owner
//   crc_en/crc_data              : engine start pulse and held payload
//   crc_o_valid/crc_o_data       : engine done strobe, result one cycle later
// Modports: slave = the arbiter, master = requesters + engine.
// ---------------------------------------------------------------------------
interface crc_arbiter_if #(
    parameter int NREQ = 4,
    parameter int DW   = 128
);
    import crc_arb_pkg::*;

    logic [NREQ-1:0]    req_valid;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_ready;
    logic               rsp_valid;
    logic [2:0]         rsp_id;
    logic [CRC_W-1:0]   rsp_crc;
    logic               rsp_err;
    logic               crc_en;
    logic [DW-1:0]      crc_data;
    logic               crc_o_valid;
    logic [CRC_W-1:0]   crc_o_data;

    modport slave (
        input  req_valid, req_data, crc_o_valid, crc_o_data,
        output req_ready, rsp_valid, rsp_id, rsp_crc, rsp_err, crc_en, crc_data
    );

    modport master (
        output req_valid, req_data, crc_o_valid, crc_o_data,
        input  req_ready, rsp_valid, rsp_id, rsp_crc, rsp_err, crc_en, crc_data
    );

endinterface

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin pick. The pointer register lives in the
// parent; this block only turns (valid, ptr) into a one-hot grant.
//   valid : NREQ request lines
//   ptr   : index with highest priority this cycle
//   grant : one-hot winner (all zero when nothing is valid)
//   idx   : winner index, found : any request valid
// ---------------------------------------------------------------------------
module rr_arbiter
    import crc_arb_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0] valid,
    input  logic [2:0]      ptr,
    output logic [NREQ-1:0] grant,
    output logic [2:0]      idx,
    output logic            found
);

    logic [MAX_REQ-1:0] valid_ext_s;
    pick_t              pick_s;

    assign valid_ext_s = MAX_REQ'(valid);
    assign pick_s      = rr_pick(valid_ext_s, ptr, NREQ);
    assign idx         = pick_s.idx;
    assign found       = pick_s.found;

    // Decode the picked index into a one-hot grant vector.
    always_comb begin
        grant = {NREQ{1'b0}};
        for (int i = 0; i < NREQ; i++) begin
            grant[i] = pick_s.found && (pick_s.idx == 3'(i));
        end
    end

endmodule

// File: rtl/crc_arbiter.sv
// ---------------------------------------------------------------------------
// crc_arbiter
// Round-robin scheduler sharing one CRC-3 (x^3+x+1) engine among NREQ
// requesters. One job in flight: grant + latch payload (IDLE), pulse crc_en
// (ISSUE), hold crc_data until the engine finishes (WAIT), capture the result
// the cycle after crc_o_valid (CAPTURE), strobe rsp_* in the next IDLE cycle.
// Ports:
//   clk, rst : clock, asynchronous active-high reset (also resets the engine)
//   bus      : crc_arbiter_if.slave (requests, response, engine handshake)
// Optional build macro CRC_TIMEOUT_EN: bounds WAIT to TIMEOUT cycles after
// crc_en; on expiry reports rsp_err=1 and parks in FLUSH until the engine's
// late crc_o_valid is seen. Without it WAIT is unbounded and rsp_err is 0.
// ---------------------------------------------------------------------------
module crc_arbiter
    import crc_arb_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int DW      = 128,
    parameter int TIMEOUT = 200
) (
    input  logic           clk,
    input  logic           rst,
    crc_arbiter_if.slave   bus
);

    // Reject configurations the counter and index widths cannot represent.
    if ((NREQ < 2) || (NREQ > MAX_REQ) || (TIMEOUT <= NOMINAL_LAT) || (TIMEOUT > 255)) begin : g_cfg_err
        $error("crc_arbiter: illegal NREQ/TIMEOUT parameter combination");
    end

    state_e           state_r;
    logic [2:0]       ptr_r;
    logic [2:0]       owner_r;
    logic [DW-1:0]    payload_r;
    logic             crc_en_r;
    logic             rsp_valid_r;
    logic [2:0]       rsp_id_r;
    logic [CRC_W-1:0] rsp_crc_r;

    logic [NREQ-1:0]  grant_s;
    logic [2:0]       win_idx_s;
    logic             win_found_s;
    logic             take_s;
    logic [2:0]       next_ptr_s;
    logic [DW-1:0]    sel_payload_s;

`ifdef CRC_TIMEOUT_EN
    // Counter holds (WAIT cycles - 1); matching TIMEOUT-2 puts the error
    // strobe exactly TIMEOUT cycles after the crc_en cycle.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 2);
    logic [7:0]       wait_cnt_r;
    logic             rsp_err_r;
`endif

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .valid (bus.req_valid),
        .ptr   (ptr_r),
        .grant (grant_s),
        .idx   (win_idx_s),
        .found (win_found_s)
    );

    // Grant only while idle and out of reset so req_ready reads 0 in reset.
    assign take_s        = (state_r == IDLE) && win_found_s && !rst;
    assign next_ptr_s    = (win_idx_s == 3'(NREQ - 1)) ? 3'd0 : (win_idx_s + 3'd1);
    assign sel_payload_s = bus.req_data[int'(win_idx_s) * DW +: DW];

    assign bus.req_ready = take_s ? grant_s : {NREQ{1'b0}};
    assign bus.crc_en    = crc_en_r;
    assign bus.crc_data  = payload_r;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_id    = rsp_id_r;
    assign bus.rsp_crc   = rsp_crc_r;
`ifdef CRC_TIMEOUT_EN
    assign bus.rsp_err   = rsp_err_r;
`else
    assign bus.rsp_err   = 1'b0;
`endif

    // Scheduler FSM with registered engine-start and response outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            ptr_r       <= 3'd0;
            owner_r     <= 3'd0;
            payload_r   <= {DW{1'b0}};
            crc_en_r    <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_id_r    <= 3'd0;
            rsp_crc_r   <= {CRC_W{1'b0}};
`ifdef CRC_TIMEOUT_EN
            wait_cnt_r  <= 8'd0;
            rsp_err_r   <= 1'b0;
`endif
        end else begin
            crc_en_r    <= 1'b0;
            rsp_valid_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (take_s) begin
                        payload_r <= sel_payload_s;
                        owner_r   <= win_idx_s;
                        ptr_r     <= next_ptr_s;
                        crc_en_r  <= 1'b1;
                        state_r   <= ISSUE;
                    end else begin
                        state_r   <= IDLE;
                    end
                end
                ISSUE: begin
`ifdef CRC_TIMEOUT_EN
                    wait_cnt_r <= 8'd0;
`endif
                    state_r    <= WAIT;
                end
                WAIT: begin
                    if (bus.crc_o_valid) begin
                        state_r <= CAPTURE;
`ifdef CRC_TIMEOUT_EN
                    end else if (wait_cnt_r == TO_LAST) begin
                        rsp_valid_r <= 1'b1;
                        rsp_err_r   <= 1'b1;
                        rsp_crc_r   <= {CRC_W{1'b0}};
                        rsp_id_r    <= owner_r;
                        state_r     <= FLUSH;
                    end else begin
                        wait_cnt_r  <= wait_cnt_r + 8'd1;
                        state_r     <= WAIT;
`else
                    end else begin
                        state_r <= WAIT;
`endif
                    end
                end
                CAPTURE: begin
                    rsp_crc_r   <= bus.crc_o_data;
                    rsp_id_r    <= owner_r;
                    rsp_valid_r <= 1'b1;
`ifdef CRC_TIMEOUT_EN
                    rsp_err_r   <= 1'b0;
`endif
                    state_r     <= IDLE;
                end
`ifdef CRC_TIMEOUT_EN
                // The late engine result is dropped; only its strobe matters.
                FLUSH: begin
                    if (bus.crc_o_valid) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= FLUSH;
                    end
                end
`endif
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_crc_arbiter.sv
// ---------------------------------------------------------------------------
// tb_crc_arbiter
// Directed bench for crc_arbiter. Stimulus pushes expected grants and
// responses (hand-computed CRC-3 values) into queues; a negedge monitor pops
// and compares whenever the DUT shows req_ready or rsp_valid. A stub engine
// answers crc_en after NOMINAL_LAT cycles using a bit-serial CRC-3.
// ---------------------------------------------------------------------------
module tb_crc_arbiter;
    import crc_arb_pkg::*;

    localparam int NREQ    = 4;
    localparam int DW      = 128;
    localparam int TIMEOUT = 200;
    localparam int JOB     = 133;

    typedef struct {
        logic [2:0] id;
        logic [2:0] crc;
        logic       err;
        int         lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    crc_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus ();

    crc_arbiter #(.NREQ(NREQ), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t          exp_q[$];
    int            exp_grant_q[$];
    int            grant_cyc_q[$];
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            job_grant_cyc = 0;
    logic [NREQ-1:0] drop_mask = '0;
    exp_t          mon_e;
    int            mon_g;

    logic [DW-1:0] eng_data = '0;
    int            eng_cnt = 0;
    logic          eng_pend = 1'b0;
    logic          eng_mute = 1'b0;
    logic          eng_kick = 1'b0;

    function automatic logic [2:0] crc3_model(input logic [DW-1:0] d);
        logic [2:0] r;
        logic       fb;
        r = 3'b000;
        for (int i = DW - 1; i >= 0; i--) begin
            fb = r[2] ^ d[i];
            r  = {r[1], r[0] ^ fb, fb};
        end
        return r;
    endfunction

    function automatic int oh_idx(input logic [NREQ-1:0] v);
        for (int i = 0; i < NREQ; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic expect_grant(input int id);
        exp_grant_q.push_back(id);
    endtask

    task automatic expect_rsp(input int id, input logic [2:0] crc, input logic err, input int lat);
        exp_t e;
        e.id  = 3'(id);
        e.crc = crc;
        e.err = err;
        e.lat = lat;
        exp_q.push_back(e);
    endtask

    task automatic drive_slot();
        @(posedge clk);
        #2;
    endtask

    task automatic raise(input int i, input logic [DW-1:0] d);
        bus.req_data[i*DW +: DW] = d;
        bus.req_valid[i]         = 1'b1;
    endtask

    task automatic wait_drain(input string name, input int budget);
        for (int i = 0; i < budget; i++) begin
            if ((exp_q.size() == 0) && (exp_grant_q.size() == 0)) break;
            @(negedge clk);
        end
        chk(name, exp_q.size() + exp_grant_q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        drive_slot();
        rst = 1'b1;
        exp_q.delete();
        exp_grant_q.delete();
        grant_cyc_q.delete();
        repeat (2) drive_slot();
        rst = 1'b0;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Release a requester one step after the edge that accepted it.
    always @(posedge clk) begin
        #1;
        if (drop_mask != '0) begin
            bus.req_valid = bus.req_valid & ~drop_mask;
            drop_mask     = '0;
        end
    end

    // Stub engine: answers crc_en after NOMINAL_LAT cycles, data one cycle later.
    initial begin
        forever begin
            @(posedge clk or posedge rst);
            #1;
            if (rst) begin
                bus.crc_o_valid = 1'b0;
                bus.crc_o_data  = 3'b000;
                eng_cnt         = 0;
                eng_pend        = 1'b0;
            end else begin
                bus.crc_o_valid = 1'b0;
                if (eng_pend) begin
                    bus.crc_o_data = crc3_model(eng_data);
                    eng_pend       = 1'b0;
                end
                if (eng_kick) begin
                    bus.crc_o_valid = 1'b1;
                    eng_kick        = 1'b0;
                end else if (eng_cnt > 0) begin
                    eng_cnt--;
                    if (eng_cnt == 0) begin
                        chk("crc_data_stable", bus.crc_data === eng_data, 1);
                        if (!eng_mute) begin
                            bus.crc_o_valid = 1'b1;
                            eng_pend        = 1'b1;
                        end
                    end
                end
                if (bus.crc_en === 1'b1) begin
                    eng_data = bus.crc_data;
                    eng_cnt  = NOMINAL_LAT;
                end
            end
        end
    end

    // Monitor: response first (uses the current job), then crc_en, then grant.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.rsp_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("rsp_id", bus.rsp_id, mon_e.id);
                    chk("rsp_crc", bus.rsp_crc, mon_e.crc);
                    chk("rsp_err", bus.rsp_err, mon_e.err);
                    chk("rsp_latency", cyc - job_grant_cyc, mon_e.lat);
                end
            end
            if (bus.crc_en === 1'b1) begin
                chk("crc_en_latency", cyc - job_grant_cyc, 1);
            end
            if (bus.req_ready !== '0) begin
                chk("ready_onehot", $onehot(bus.req_ready), 1);
                if (exp_grant_q.size() == 0) begin
                    chk("unexpected_grant", 1, 0);
                end else begin
                    mon_g = exp_grant_q.pop_front();
                    chk("grant_idx", oh_idx(bus.req_ready), mon_g);
                end
                job_grant_cyc = cyc;
                grant_cyc_q.push_back(cyc);
                drop_mask = bus.req_ready;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int g;
        int target;
        bus.req_valid   = '0;
        bus.req_data    = '0;
        bus.crc_o_valid = 1'b0;
        bus.crc_o_data  = 3'b000;

        // Reset values, with a request already pending during reset.
        raise(0, {DW{1'b0}});
        repeat (3) @(negedge clk);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_id", bus.rsp_id, 0);
        chk("rst_rsp_crc", bus.rsp_crc, 0);
        chk("rst_rsp_err", bus.rsp_err, 0);
        chk("rst_crc_en", bus.crc_en, 0);
        chk("rst_crc_data", bus.crc_data === {DW{1'b0}}, 1);
        chk("rst_req_ready", bus.req_ready, 0);

        // Single request, then a new request raised exactly in the rsp cycle.
        expect_grant(0);
        expect_rsp(0, 3'b000, 1'b0, JOB);
        drive_slot();
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (exp_grant_q.size() == 0) break;
            @(negedge clk);
        end
        chk("t1_grant_seen", exp_grant_q.size(), 0);
        g = job_grant_cyc;
        for (int i = 0; i < 300; i++) begin
            drive_slot();
            if (cyc >= g + JOB) break;
        end
        expect_grant(1);
        expect_rsp(1, 3'b110, 1'b0, JOB);
        raise(1, 128'h2);
        wait_drain("t1_drain", 600);
        chk("t1_grant_count", grant_cyc_q.size(), 2);
        if (grant_cyc_q.size() == 2) chk("t1_b2b_spacing", grant_cyc_q[1] - grant_cyc_q[0], JOB);

        // All four requesting from reset; requester 0 comes back for a second job.
        do_reset();
        expect_grant(0); expect_grant(1); expect_grant(2); expect_grant(3); expect_grant(0);
        expect_rsp(0, 3'b011, 1'b0, JOB);
        expect_rsp(1, 3'b110, 1'b0, JOB);
        expect_rsp(2, 3'b110, 1'b0, JOB);
        expect_rsp(3, 3'b101, 1'b0, JOB);
        expect_rsp(0, 3'b001, 1'b0, JOB);
        raise(0, 128'h1);
        raise(1, 128'h2);
        raise(2, 128'h100);
        raise(3, 128'h8000_0000_0000_0000_0000_0000_0000_0001);
        for (int i = 0; i < 50; i++) begin
            drive_slot();
            if (!bus.req_valid[0]) break;
        end
        raise(0, 128'h10);
        wait_drain("t2_drain", 1200);
        chk("t2_grant_count", grant_cyc_q.size(), 5);
        for (int i = 1; i < grant_cyc_q.size(); i++) begin
            chk("t2_spacing", grant_cyc_q[i] - grant_cyc_q[i-1], JOB);
        end

        // Move ptr to 2, then requests 1 and 3 together: 3 wins first.
        expect_grant(1);
        expect_rsp(1, 3'b111, 1'b0, JOB);
        drive_slot();
        raise(1, 128'h4);
        wait_drain("t3a_drain", 600);
        expect_grant(3); expect_grant(1);
        expect_rsp(3, 3'b010, 1'b0, JOB);
        expect_rsp(1, 3'b101, 1'b0, JOB);
        drive_slot();
        raise(1, 128'h8);
        raise(3, 128'h20);
        wait_drain("t3b_drain", 800);

        // Reset in the middle of a job: outputs clear, no response appears.
        do_reset();
        expect_grant(2);
        drive_slot();
        raise(2, 128'h40);
        for (int i = 0; i < 20; i++) begin
            if (exp_grant_q.size() == 0) break;
            @(negedge clk);
        end
        chk("t4_grant_seen", exp_grant_q.size(), 0);
        target = job_grant_cyc + 60;
        for (int i = 0; i < 100; i++) begin
            if (cyc >= target) break;
            @(negedge clk);
        end
        rst = 1'b1;
        #1;
        chk("midrst_crc_en", bus.crc_en, 0);
        chk("midrst_crc_data", bus.crc_data === {DW{1'b0}}, 1);
        chk("midrst_rsp_valid", bus.rsp_valid, 0);
        chk("midrst_req_ready", bus.req_ready, 0);
        exp_q.delete();
        repeat (3) drive_slot();
        rst = 1'b0;
        repeat (150) @(negedge clk);
        // ptr must be back at 0, so 2 beats 3.
        expect_grant(2); expect_grant(3);
        expect_rsp(2, 3'b100, 1'b0, JOB);
        expect_rsp(3, 3'b011, 1'b0, JOB);
        drive_slot();
        raise(2, 128'h40);
        raise(3, 128'h1);
        wait_drain("t4_drain", 800);

`ifdef CRC_TIMEOUT_EN
        // Silent engine: error strobe TIMEOUT cycles after crc_en, then FLUSH.
        do_reset();
        eng_mute = 1'b1;
        expect_grant(0);
        expect_rsp(0, 3'b000, 1'b1, 1 + TIMEOUT);
        drive_slot();
        raise(0, 128'h1);
        wait_drain("to_drain", 600);
        drive_slot();
        raise(1, 128'h2);
        g = 0;
        repeat (30) begin
            @(negedge clk);
            if (bus.req_ready !== '0) g++;
        end
        chk("flush_no_grant", g, 0);
        expect_grant(1);
        expect_rsp(1, 3'b110, 1'b0, JOB);
        eng_mute = 1'b0;
        drive_slot();
        eng_kick = 1'b1;
        wait_drain("to_recover_drain", 600);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
